waveform_capture_buffer: RTL

//  Sits directly downstream of the ADC timing manager. Takes each new 8-bit ADC sample
//  (curveData, qualified by a change of the 10-bit sample index adcToVgaCount), applies a

---
 rtl/waveform_capture_buffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/waveform_capture_buffer.sv
// Trigger-qualified sweep capture into a double-buffered sample RAM, with a
// registered per-column read port for the VGA renderer.
module waveform_capture_buffer #(
    parameter int unsigned DEPTH        = 640,
    parameter int unsigned DW           = 8,
    parameter int unsigned AW           = 10,
    parameter int unsigned AUTO_TIMEOUT = 1280
) (
    input  logic          Clk,
    input  logic          capRst,
    input  logic [DW-1:0] curveData,
    input  logic [AW-1:0] adcToVgaCount,
    input  logic [DW-1:0] trigLevel,
    input  logic          trigMode,
    input  logic          frameStart,
    input  logic [AW-1:0] pixX,
    output logic [DW-1:0] pixData,
    output logic          captureBusy,
    output logic          bankSel,
    output logic          trigged
);

    localparam int unsigned PW        = AW + 1;
    localparam int unsigned MEM_WORDS = 2 * DEPTH;

    localparam logic [1:0] S_WAIT_TRIG = 2'd0;
    localparam logic [1:0] S_CAPTURE   = 2'd1;
    localparam logic [1:0] S_DONE      = 2'd2;

    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [PW-1:0] CNT_LAST  = PW'(AUTO_TIMEOUT - 1);
    localparam logic [PW-1:0] BANK_OFS  = PW'(DEPTH);
    localparam logic [AW-1:0] COL_LIMIT = AW'(DEPTH);

    logic [DW-1:0] mem [0:MEM_WORDS-1];

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] prev_idx_q, prev_idx_d;
    logic [DW-1:0] prev_smp_q, prev_smp_d;
    logic          prev_valid_q, prev_valid_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          pending_q, pending_d;
    logic          bank_q, bank_d;
    logic          trigged_q, trigged_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] pix_q, pix_d;

    logic          smp_c;
    logic          hit_c;
    logic          we_c;
    logic          col_ok_c;
    logic [PW-1:0] wr_ptr_c;
    logic [PW-1:0] wr_addr_c;
    logic [PW-1:0] rd_addr_c;

    // Next-state, RAM write control and read-port mux
    always_comb begin
        state_d      = state_q;
        prev_idx_d   = adcToVgaCount;
        prev_smp_d   = prev_smp_q;
        prev_valid_d = prev_valid_q;
        wptr_d       = wptr_q;
        cnt_d        = cnt_q;
        pending_d    = pending_q;
        bank_d       = bank_q;
        trigged_d    = trigged_q;
        we_c         = 1'b0;
        wr_ptr_c     = wptr_q;

        smp_c = (adcToVgaCount != prev_idx_q);
        hit_c = prev_valid_q && (prev_smp_q < trigLevel) && (curveData >= trigLevel);

        if (smp_c) begin
            prev_smp_d   = curveData;
            prev_valid_d = 1'b1;
        end

        case (state_q)
            S_WAIT_TRIG: begin
                if (smp_c) begin
                    if (hit_c || (!trigMode && (cnt_q >= CNT_LAST))) begin
                        we_c      = 1'b1;
                        wr_ptr_c  = PW'(0);
                        wptr_d    = PW'(1);
                        pending_d = hit_c;
                        state_d   = S_CAPTURE;
                    end else if (cnt_q < CNT_LAST) begin
                        cnt_d = cnt_q + PW'(1);
                    end
                end
            end
            S_CAPTURE: begin
                if (smp_c) begin
                    we_c   = 1'b1;
                    wptr_d = wptr_q + PW'(1);
                    if (wptr_q == LAST_PTR) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Swap wins over a same-cycle sample; the first post-swap sample cannot trigger
                if (frameStart) begin
                    bank_d       = ~bank_q;
                    trigged_d    = pending_q;
                    wptr_d       = PW'(0);
                    cnt_d        = PW'(0);
                    prev_valid_d = 1'b0;
                    state_d      = S_WAIT_TRIG;
                end
            end
            default: state_d = S_WAIT_TRIG;
        endcase

        busy_d    = (state_d == S_CAPTURE);
        wr_addr_c = (bank_q ? PW'(0) : BANK_OFS) + wr_ptr_c;
        col_ok_c  = (pixX < COL_LIMIT);
        rd_addr_c = col_ok_c ? ((bank_q ? BANK_OFS : PW'(0)) + PW'(pixX)) : PW'(0);
        pix_d     = col_ok_c ? mem[rd_addr_c] : '0;
    end

    always_ff @(posedge Clk or negedge capRst) begin
        if (!capRst) begin
            state_q      <= S_WAIT_TRIG;
            prev_idx_q   <= '0;
            prev_smp_q   <= '0;
            prev_valid_q <= 1'b0;
            wptr_q       <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            bank_q       <= 1'b0;
            trigged_q    <= 1'b0;
            busy_q       <= 1'b0;
            pix_q        <= '0;
        end else begin
            state_q      <= state_d;
            prev_idx_q   <= prev_idx_d;
            prev_smp_q   <= prev_smp_d;
            prev_valid_q <= prev_valid_d;
            wptr_q       <= wptr_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            bank_q       <= bank_d;
            trigged_q    <= trigged_d;
            busy_q       <= busy_d;
            pix_q        <= pix_d;
        end
    end

    // Sample RAM is deliberately not reset
    always_ff @(posedge Clk) begin
        if (we_c) begin
            mem[wr_addr_c] <= curveData;
        end
    end

    assign pixData     = pix_q;
    assign captureBusy = busy_q;
    assign bankSel     = bank_q;
    assign trigged     = trigged_q;

endmodule
